wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue.sv | 89 ++++++++
 tb/tb_wb_queue.sv | 125 ++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// wb_queue: circular writeback FIFO between execute/memory and the register file,
// with combinational youngest-entry forwarding to decode.
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wb_valid,
    input  logic [2:0]                 wb_dest,
    input  logic [15:0]                wb_data,
    output logic                       wb_ready,
    input  logic                       rf_stall,
    output logic                       rf_load,
    output logic [2:0]                 rf_dest,
    output logic [15:0]                rf_in,
    input  logic [2:0]                 fwd_reg,
    output logic                       fwd_hit,
    output logic [15:0]                fwd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [2:0]    dest_q [DEPTH];
    logic [2:0]    dest_d [DEPTH];
    logic [15:0]   data_q [DEPTH];
    logic [15:0]   data_d [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          not_empty, push;
    logic [AW-1:0] idx;

    always_comb begin
        dest_d     = dest_q;
        data_d     = data_q;
        head_d     = head_q;
        tail_d     = tail_q;
        overflow_d = overflow_q;
        not_empty  = count_q != '0;
        wb_ready   = count_q < CW'(DEPTH);
        rf_load    = not_empty && !rf_stall;
        rf_dest    = not_empty ? dest_q[head_q] : '0;
        rf_in      = not_empty ? data_q[head_q] : '0;
        push       = wb_valid && wb_ready;
        if (push) begin
            dest_d[tail_q] = wb_dest;
            data_d[tail_q] = wb_data;
            tail_d         = tail_q + AW'(1);
        end
        if (wb_valid && !wb_ready) overflow_d = 1'b1;
        if (rf_load) head_d = head_q + AW'(1);
        count_d = count_q + CW'(push) - CW'(rf_load);
        // Walk oldest to youngest so the last match left standing is the youngest.
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + AW'(i);
            if (CW'(i) < count_q && dest_q[idx] == fwd_reg) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
        count    = count_q;
        overflow = overflow_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                dest_q[i] <= '0;
                data_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            dest_q     <= dest_d;
            data_q     <= data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed scenarios plus random traffic checked against a queue-based reference model.
module tb_wb_queue;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        wb_valid;
    logic [2:0]  wb_dest;
    logic [15:0] wb_data;
    logic        wb_ready;
    logic        rf_stall;
    logic        rf_load;
    logic [2:0]  rf_dest;
    logic [15:0] rf_in;
    logic [2:0]  fwd_reg;
    logic        fwd_hit;
    logic [15:0] fwd_data;
    logic [2:0]  count;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [18:0] mq[$];
    logic        movf;

    wb_queue #(.DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .wb_valid(wb_valid), .wb_dest(wb_dest),
        .wb_data(wb_data), .wb_ready(wb_ready), .rf_stall(rf_stall), .rf_load(rf_load),
        .rf_dest(rf_dest), .rf_in(rf_in), .fwd_reg(fwd_reg), .fwd_hit(fwd_hit),
        .fwd_data(fwd_data), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [2:0] d, input logic [15:0] x,
                        input logic s, input logic [2:0] f);
        logic        e_load, e_push, e_hit;
        logic [15:0] e_fd;
        wb_valid = v; wb_dest = d; wb_data = x; rf_stall = s; fwd_reg = f;
        #4;
        e_load = mq.size() != 0 && !s;
        e_push = v && mq.size() < 4;
        e_hit  = 1'b0;
        e_fd   = '0;
        foreach (mq[i]) if (mq[i][18:16] == f) begin
            e_hit = 1'b1;
            e_fd  = mq[i][15:0];
        end
        chk("wb_ready", 32'(wb_ready), 32'(mq.size() < 4));
        chk("rf_load", 32'(rf_load), 32'(e_load));
        chk("rf_dest", 32'(rf_dest), mq.size() != 0 ? 32'(mq[0][18:16]) : 32'd0);
        chk("rf_in", 32'(rf_in), mq.size() != 0 ? 32'(mq[0][15:0]) : 32'd0);
        chk("count", 32'(count), 32'(mq.size()));
        chk("overflow", 32'(overflow), 32'(movf));
        chk("fwd_hit", 32'(fwd_hit), 32'(e_hit));
        chk("fwd_data", 32'(fwd_data), 32'(e_fd));
        @(posedge clk);
        if (v && mq.size() >= 4) movf = 1'b1;
        if (e_load) void'(mq.pop_front());
        if (e_push) mq.push_back({d, x});
        #1;
    endtask

    initial begin
        reset_n = 1'b0; wb_valid = 1'b0; wb_dest = '0; wb_data = '0;
        rf_stall = 1'b0; fwd_reg = '0; movf = 1'b0;
        #3;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_wb_ready", 32'(wb_ready), 32'd1);
        chk("rst_rf_load", 32'(rf_load), 32'd0);
        chk("rst_fwd_hit", 32'(fwd_hit), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        // single write
        step(1, 3'd3, 16'h1234, 0, 3'd3);
        step(0, 0, 0, 0, 3'd3);
        step(0, 0, 0, 0, 3'd3);
        // forward youngest (queue left with 3 entries)
        step(1, 3'd2, 16'h0001, 1, 3'd2);
        step(1, 3'd5, 16'h0AAA, 1, 3'd2);
        step(1, 3'd2, 16'h0002, 1, 3'd2);
        step(0, 0, 0, 1, 3'd2);
        step(0, 0, 0, 1, 3'd7);
        step(0, 0, 0, 1, 3'd5);
        // drain, then fill and overflow
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 3'd2);
        for (int i = 0; i < 5; i++) step(1, 3'(i + 1), 16'(16'hA000 + i), 1, 3'(i));
        // full with simultaneous drain and dropped request
        step(1, 3'd7, 16'hDEAD, 0, 3'd7);
        step(0, 0, 0, 1, 3'd4);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 3'd1);
        // wrap-around with alternating stall
        for (int i = 0; i < 10; i++) step(1, 3'(i), 16'(16'h0B00 + i), 1'(i % 2), 3'(i));
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1'(i % 2), 3'(i));
        // async reset mid-operation with 3 pending
        for (int i = 0; i < 3; i++) step(1, 3'(i + 4), 16'(16'hC000 + i), 1, 3'd4);
        rf_stall = 1'b0; wb_valid = 1'b0;
        reset_n = 1'b0;
        #2;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_rf_load", 32'(rf_load), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        chk("mid_rst_fwd_hit", 32'(fwd_hit), 32'd0);
        mq.delete();
        movf = 1'b0;
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 3'(i + 4));
        // random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
                 1'($urandom_range(0, 99) < 45), 3'($urandom));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
